// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate decoder (I/S/B/U/J) behind a 2-entry valid/ready output FIFO
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit RV64 = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            unknown
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    logic [6:0]        op;
    logic              is_i, is_s, is_b, is_u, is_j, is_n;
    logic signed [31:0] s32;
    logic [XLEN-1:0]   d_imm;
    logic [2:0]        d_fmt;
    logic              d_unk;
    always_comb begin
        op    = instr[6:0];
        is_i  = op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || (RV64 && op == 7'b0011011);
        is_s  = op == 7'b0100011;
        is_b  = op == 7'b1100011;
        is_u  = op == 7'b0110111 || op == 7'b0010111;
        is_j  = op == 7'b1101111;
        is_n  = op == 7'b0110011 || op == 7'b0111011 || op == 7'b1110011 || op == 7'b0001111;
        s32   = is_i ? {{20{instr[31]}}, instr[31:20]}
              : is_s ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
              : is_b ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0}
              : is_u ? {instr[31:12], 12'b0}
              : is_j ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0}
              : '0;
        d_fmt = is_i ? 3'd1 : is_s ? 3'd2 : is_b ? 3'd3 : is_u ? 3'd4 : is_j ? 3'd5 : 3'd0;
        d_unk = !(is_i || is_s || is_b || is_u || is_j || is_n);
        d_imm = XLEN'(s32);
    end
    logic [XLEN-1:0] imm_m [2];
    logic [2:0]      fmt_m [2];
    logic            unk_m [2];
    logic            wptr, rptr, push, pop;
    logic [1:0]      count;
    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    // storage needs no reset: every read is gated by out_valid
    always_ff @(posedge clk) begin
        if (push) begin
            imm_m[wptr] <= d_imm;
            fmt_m[wptr] <= d_fmt;
            unk_m[wptr] <= d_unk;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else if (flush) begin
            count <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) wptr <= !wptr;
            if (pop)  rptr <= !rptr;
        end
    end
    assign imm     = out_valid ? imm_m[rptr] : '0;
    assign fmt     = out_valid ? fmt_m[rptr] : 3'd0;
    assign unknown = out_valid ? unk_m[rptr] : 1'b0;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: XLEN=32/RV64=0 and XLEN=64/RV64=1 instances driven in lockstep against a queue reference model
module tb_imm_gen_pipe;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic        in_ready32, out_valid32, unk32, in_ready64, out_valid64, unk64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;
    int          n_vec = 0, n_err = 0;
    logic [31:0] q[$];

    typedef struct { logic [63:0] imm; logic [2:0] fmt; logic unk; } ref_t;

    imm_gen_pipe #(.XLEN(32), .RV64(1'b0)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .instr(instr), .out_valid(out_valid32),
        .out_ready(out_ready), .imm(imm32), .fmt(fmt32), .unknown(unk32));
    imm_gen_pipe #(.XLEN(64), .RV64(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .instr(instr), .out_valid(out_valid64),
        .out_ready(out_ready), .imm(imm64), .fmt(fmt64), .unknown(unk64));

    always #5 clk = !clk;

    function automatic ref_t model(input logic [31:0] w, input bit rv64);
        ref_t r;
        longint v;
        r.imm = 0; r.fmt = 0; r.unk = 0; v = 0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: begin r.fmt = 1; v = longint'($signed(w[31:20])); end
            7'h1B: if (rv64) begin r.fmt = 1; v = longint'($signed(w[31:20])); end else r.unk = 1;
            7'h23: begin r.fmt = 2; v = longint'($signed({w[31:25], w[11:7]})); end
            7'h63: begin r.fmt = 3; v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
            7'h37, 7'h17: begin r.fmt = 4; v = longint'($signed(w[31:12])) * 4096; end
            7'h6F: begin r.fmt = 5; v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            7'h33, 7'h3B, 7'h73, 7'h0F: ;
            default: r.unk = 1;
        endcase
        r.imm = v;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        bit push, pop;
        @(negedge clk);
        in_valid = v; instr = w; out_ready = rdy; flush = fl;
        push = v && q.size() < 2 && !fl;
        pop  = q.size() > 0 && rdy && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(w);
        end
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_vec++;
        if (out_valid32 !== 0 || imm32 !== 0 || fmt32 !== 0 || unk32 !== 0 ||
            out_valid64 !== 0 || imm64 !== 0 || fmt64 !== 0 || unk64 !== 0) begin
            n_err++;
            $display("FAIL reset_outputs: v=%b/%b imm=%h/%h fmt=%0d/%0d unk=%b/%b, required all 0",
                     out_valid32, out_valid64, imm32, imm64, fmt32, fmt64, unk32, unk64);
        end
        @(negedge clk); rst_n = 1'b1; q.delete();
        #1;
        n_vec++;
        if (in_ready32 !== 1 || in_ready64 !== 1) begin
            n_err++; $display("FAIL reset_in_ready: %b/%b, required 1", in_ready32, in_ready64);
        end
    endtask

    task automatic test_formats;
        logic [31:0] ins [9] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
                                 32'h001000EF, 32'h0000007F, 32'h00B50533, 32'h800002B7, 32'hFFF0001B};
        logic [31:0] ei [9]  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                 32'h00000800, 32'h0, 32'h0, 32'h80000000, 32'h0};
        logic [2:0]  ef [9]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd4, 3'd0};
        logic        eu [9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ins[i], 1'b1, 1'b0);
            n_vec++;
            if (out_valid32 !== 1 || imm32 !== ei[i] || fmt32 !== ef[i] || unk32 !== eu[i]) begin
                n_err++;
                $display("FAIL format32 %h: v=%b imm=%h fmt=%0d unk=%b, required v=1 imm=%h fmt=%0d unk=%b",
                         ins[i], out_valid32, imm32, fmt32, unk32, ei[i], ef[i], eu[i]);
            end
        end
        n_vec++;
        if (fmt64 !== 3'd1 || unk64 !== 0 || imm64 !== 64'hFFFFFFFFFFFFFFFF) begin
            n_err++;
            $display("FAIL opimm32_rv64: imm=%h fmt=%0d unk=%b, required FFFFFFFFFFFFFFFF/1/0", imm64, fmt64, unk64);
        end
        drive(1'b1, 32'h800002B7, 1'b1, 1'b0);
        n_vec++;
        if (imm64 !== 64'hFFFFFFFF80000000 || fmt64 !== 3'd4) begin
            n_err++; $display("FAIL lui64: imm=%h fmt=%0d, required FFFFFFFF80000000/4", imm64, fmt64);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid32 !== 0 || imm32 !== 0 || fmt32 !== 0 || unk32 !== 0) begin
            n_err++; $display("FAIL empty_zero: v=%b imm=%h fmt=%0d unk=%b, required 0", out_valid32, imm32, fmt32, unk32);
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 32'h00100093, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, 1'b0, 1'b0);
        n_vec++;
        if (in_ready32 !== 0 || out_valid32 !== 1 || imm32 !== 32'd1) begin
            n_err++; $display("FAIL full_after_two: in_ready=%b v=%b imm=%h, required 0/1/1", in_ready32, out_valid32, imm32);
        end
        drive(1'b1, 32'h00300093, 1'b0, 1'b0);
        n_vec++;
        if (in_ready32 !== 0 || imm32 !== 32'd1) begin
            n_err++; $display("FAIL third_held: in_ready=%b imm=%h, required 0/1", in_ready32, imm32);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid32 !== 1 || imm32 !== 32'd2 || in_ready32 !== 1) begin
            n_err++; $display("FAIL drain_second: v=%b imm=%h in_ready=%b, required 1/2/1", out_valid32, imm32, in_ready32);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        n_vec++;
        if (out_valid32 !== 0) begin
            n_err++; $display("FAIL drain_empty: v=%b, required 0", out_valid32);
        end
    endtask

    task automatic test_flush;
        drive(1'b1, 32'h00100093, 1'b0, 1'b0);
        drive(1'b1, 32'h00200093, 1'b0, 1'b0);
        drive(1'b1, 32'h00300093, 1'b1, 1'b1);
        n_vec++;
        if (out_valid32 !== 0 || in_ready32 !== 1 || out_valid64 !== 0 || imm32 !== 0) begin
            n_err++; $display("FAIL flush_clear: v=%b in_ready=%b imm=%h, required 0/1/0", out_valid32, in_ready32, imm32);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_vec++;
        if (out_valid32 !== 0) begin
            n_err++; $display("FAIL flush_push_dropped: v=%b, required 0", out_valid32);
        end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        drive(1'b1, 32'h001000EF, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid32 !== 0 || imm32 !== 0 || fmt32 !== 0 || out_valid64 !== 0 || imm64 !== 0) begin
            n_err++; $display("FAIL async_reset: v=%b imm=%h fmt=%0d imm64=%h, required 0", out_valid32, imm32, fmt32, imm64);
        end
        q.delete();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_random;
        logic [6:0] ops [18] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                                 7'h33, 7'h3B, 7'h73, 7'h0F, 7'h7F, 7'h00, 7'h13, 7'h63, 7'h6F};
        ref_t r32, r64;
        logic [31:0] w;
        bit ev;
        for (int i = 0; i < 400; i++) begin
            ev = q.size() != 0;
            r32 = ev ? model(q[0], 1'b0) : '{imm: 64'h0, fmt: 3'd0, unk: 1'b0};
            r64 = ev ? model(q[0], 1'b1) : '{imm: 64'h0, fmt: 3'd0, unk: 1'b0};
            n_vec++;
            if (out_valid32 !== ev || in_ready32 !== (q.size() != 2) || imm32 !== r32.imm[31:0] ||
                fmt32 !== r32.fmt || unk32 !== r32.unk) begin
                n_err++;
                $display("FAIL rand32 #%0d: v=%b rdy=%b imm=%h fmt=%0d unk=%b, required v=%b imm=%h fmt=%0d unk=%b",
                         i, out_valid32, in_ready32, imm32, fmt32, unk32, ev, r32.imm[31:0], r32.fmt, r32.unk);
            end
            n_vec++;
            if (out_valid64 !== ev || in_ready64 !== (q.size() != 2) || imm64 !== r64.imm ||
                fmt64 !== r64.fmt || unk64 !== r64.unk) begin
                n_err++;
                $display("FAIL rand64 #%0d: v=%b rdy=%b imm=%h fmt=%0d unk=%b, required v=%b imm=%h fmt=%0d unk=%b",
                         i, out_valid64, in_ready64, imm64, fmt64, unk64, ev, r64.imm, r64.fmt, r64.unk);
            end
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 17)];
            drive(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
